// File: rtl/cc_line_encoder_pkg.sv
// Shared types, constants and encode helpers for the 12-line active-low encoder.
package cc_line_encoder_pkg;

   localparam int unsigned LINES  = 12;
   localparam int unsigned CODE_W = 4;

   localparam logic [LINES-1:0]  IDLE_PATTERN = 12'hFFF;
   localparam logic [CODE_W-1:0] CODE_NONE    = 4'd0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      EMIT     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // One accepted key event as presented to the control FSM.
   typedef struct packed {
      logic              multi;
      logic [CODE_W-1:0] code;
   } event_t;

   // Lowest-index low line wins: bit0 -> 1 ... bit11 -> 12, none low -> 0.
   function automatic logic [CODE_W-1:0] prio_encode(input logic [LINES-1:0] s);
      logic [CODE_W-1:0] code;
      code = CODE_NONE;
      for (int i = int'(LINES) - 1; i >= 0; i--) begin
         if (!s[i]) code = CODE_W'(i + 1);
      end
      return code;
   endfunction

   // True when two or more lines are low; clearing the lowest set bit of
   // the active mask leaves something only if a second bit was set.
   function automatic logic multi_low(input logic [LINES-1:0] s);
      logic [LINES-1:0] act;
      act = ~s;
      return (act & (act - LINES'(1))) != '0;
   endfunction

endpackage

// File: rtl/cc_line_sync.sv
// Generic N-bit two-flop synchronizer with a caller-supplied reset value.
module cc_line_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] rst_value,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two back-to-back stages; q is d delayed by two edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= rst_value;
         q    <= rst_value;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cc_line_encoder.sv
// Synchronize, debounce and priority-encode 12 active-low lines into one
// code event per press, delivered on a valid/ready handshake.
module cc_line_encoder
   import cc_line_encoder_pkg::*;
#(
   parameter int unsigned DATAWIDTH_ENCODER_LINES = 12,
   parameter int unsigned DATAWIDTH_ENCODER_CODE  = 4,
   parameter int unsigned DEBOUNCE_CYCLES         = 4
) (
   input  logic                               CC_LINE_ENCODER_CLOCK_50,
   input  logic                               CC_LINE_ENCODER_RESET_InHigh,
   input  logic [DATAWIDTH_ENCODER_LINES-1:0] CC_LINE_ENCODER_lines_InBUS,
   input  logic                               CC_LINE_ENCODER_ready_In,
   output logic [DATAWIDTH_ENCODER_CODE-1:0]  CC_LINE_ENCODER_code_OutBUS,
   output logic                               CC_LINE_ENCODER_valid_Out,
   output logic                               CC_LINE_ENCODER_multi_Out
);

   localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

   logic                               clk;
   logic                               rst;
   logic [DATAWIDTH_ENCODER_LINES-1:0] sync_s;

   state_t                             state_q, state_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic [CNT_W-1:0]                   cnt_inc_c;
   logic [DATAWIDTH_ENCODER_LINES-1:0] ref_q, ref_d;
   event_t                             evt_q, evt_d;
   logic                               valid_q, valid_d;

   assign clk = CC_LINE_ENCODER_CLOCK_50;
   assign rst = CC_LINE_ENCODER_RESET_InHigh;

   cc_line_sync #(
      .WIDTH     (DATAWIDTH_ENCODER_LINES)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .rst_value (IDLE_PATTERN),
      .d         (CC_LINE_ENCODER_lines_InBUS),
      .q         (sync_s)
   );

   // Saturating increment so the counter can never wrap.
   assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ref_q   <= IDLE_PATTERN;
         evt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ref_q   <= ref_d;
         evt_q   <= evt_d;
         valid_q <= valid_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ref_d   = ref_q;
      evt_d   = evt_q;
      valid_d = valid_q;

      case (state_q)
         IDLE: begin
            if (sync_s != IDLE_PATTERN) begin
               state_d = DEBOUNCE;
               cnt_d   = '0;
               ref_d   = sync_s;
            end
         end

         DEBOUNCE: begin
            if (sync_s == IDLE_PATTERN) begin
               state_d = IDLE;
            end else if (sync_s != ref_q) begin
               ref_d = sync_s;
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               evt_d.code  = prio_encode(sync_s);
               evt_d.multi = multi_low(sync_s);
               valid_d     = 1'b1;
               state_d     = EMIT;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end

         EMIT: begin
            // Event is frozen until the consumer takes it.
            if (CC_LINE_ENCODER_ready_In) begin
               state_d = RELEASE;
               valid_d = 1'b0;
               evt_d   = '0;
               cnt_d   = '0;
            end
         end

         RELEASE: begin
            if (sync_s != IDLE_PATTERN) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign CC_LINE_ENCODER_code_OutBUS = evt_q.code;
   assign CC_LINE_ENCODER_multi_Out   = evt_q.multi;
   assign CC_LINE_ENCODER_valid_Out   = valid_q;

endmodule

// File: tb/tb_cc_line_encoder.sv
// Self-checking bench for cc_line_encoder: table-driven presses, directed
// corner sequences and random stimulus against a run-length reference model.
module tb_cc_line_encoder;

   localparam int unsigned D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic [11:0] lines;
   logic [3:0]  code;
   logic        valid;
   logic        multi;

   int checks = 0;
   int passed = 0;

   cc_line_encoder #(
      .DATAWIDTH_ENCODER_LINES (12),
      .DATAWIDTH_ENCODER_CODE  (4),
      .DEBOUNCE_CYCLES         (D)
   ) dut (
      .CC_LINE_ENCODER_CLOCK_50     (clk),
      .CC_LINE_ENCODER_RESET_InHigh (rst),
      .CC_LINE_ENCODER_lines_InBUS  (lines),
      .CC_LINE_ENCODER_ready_In     (ready),
      .CC_LINE_ENCODER_code_OutBUS  (code),
      .CC_LINE_ENCODER_valid_Out    (valid),
      .CC_LINE_ENCODER_multi_Out    (multi)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Lines reach the decision logic two edges late. An event fires once the
   // same non-idle pattern has been seen D+1 times in a row; it is held until
   // taken, and a new press is only looked for after D idle observations.
   logic [11:0] m_d1 = 12'hFFF, m_d2 = 12'hFFF, m_s, m_last = 12'hFFF;
   int          m_phase = 0;   // 0 hunting, 1 holding event, 2 draining
   int          m_run = 0, m_idle = 0;
   logic [3:0]  m_code = 4'd0;
   logic        m_valid = 1'b0, m_multi = 1'b0;
   bit          m_check_en = 1'b0;

   function automatic logic [3:0] ref_code(input logic [11:0] s);
      for (int i = 0; i < 12; i++) if (!s[i]) return 4'(i + 1);
      return 4'd0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_d1 = 12'hFFF; m_d2 = 12'hFFF; m_phase = 0; m_run = 0; m_idle = 0;
         m_code = 4'd0; m_valid = 1'b0; m_multi = 1'b0;
      end else begin
         m_s  = m_d2;
         m_d2 = m_d1;
         m_d1 = lines;
         if (m_phase == 0) begin
            if (m_s == 12'hFFF) m_run = 0;
            else if (m_run > 0 && m_s == m_last) m_run++;
            else begin m_run = 1; m_last = m_s; end
            if (m_run == D + 1) begin
               m_phase = 1; m_valid = 1'b1;
               m_code  = ref_code(m_s);
               m_multi = ($countones(~m_s) >= 2);
            end
         end else if (m_phase == 1) begin
            if (ready) begin
               m_phase = 2; m_idle = 0;
               m_valid = 1'b0; m_code = 4'd0; m_multi = 1'b0;
            end
         end else begin
            if (m_s == 12'hFFF) m_idle++;
            else m_idle = 0;
            if (m_idle == D) begin m_phase = 0; m_run = 0; end
         end
      end
   end

   // Compare every cycle against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_check_en)
         check("model_cycle", {23'd0, code, valid, multi}, {23'd0, m_code, m_valid, m_multi});
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!valid && n < 30) begin tick(); n++; end
   endtask

   // Press a pattern, expect an event at edge D+3, accept it, verify no
   // repeat while held, then release long enough to re-arm.
   task automatic press(input logic [11:0] pat, input logic [3:0] exp_code,
                        input logic exp_multi, input string name);
      int n;
      int extra;
      extra = 0;
      lines = pat;
      ready = 1'b0;
      wait_valid(n);
      check({name, "_latency"}, n, D + 3);
      check({name, "_code"}, code, exp_code);
      check({name, "_multi"}, multi, exp_multi);
      ready = 1'b1;
      tick();
      check({name, "_drop"}, valid, 1'b0);
      repeat (10) begin tick(); if (valid) extra++; end
      check({name, "_no_repeat"}, extra, 0);
      lines = 12'hFFF;
      repeat (10) tick();
      ready = 1'b0;
   endtask

   typedef struct {
      logic [11:0] pat;
      logic [3:0]  code;
      logic        multi;
      string       name;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int n;
      int bad;
      logic [11:0] one;

      // Table: round-trip of every one-hot-low code plus multi-line cases.
      for (int k = 1; k <= 12; k++) begin
         one = 12'h001;
         tbl.push_back('{~(one << (k - 1)), 4'(k), 1'b0, $sformatf("roundtrip%0d", k)});
      end
      tbl.push_back('{12'hFF5, 4'd2,  1'b1, "multi_b1b3"});
      tbl.push_back('{12'h000, 4'd1,  1'b1, "multi_all"});
      tbl.push_back('{12'h3FF, 4'd11, 1'b1, "multi_top"});

      // Reset state.
      rst = 1'b1; lines = 12'hFFF; ready = 1'b0;
      tick();
      m_check_en = 1'b1;
      check("reset_outputs", {code, valid, multi}, 6'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();

      // First press from the plan: code 1, then code 12.
      press(12'hFFE, 4'd1, 1'b0, "first");
      press(12'h7FF, 4'd12, 1'b0, "last_line");

      foreach (tbl[i]) press(tbl[i].pat, tbl[i].code, tbl[i].multi, tbl[i].name);

      // Bounce: short runs must never produce an event.
      bad = 0;
      for (int seg = 0; seg < 6; seg++) begin
         lines = (seg % 2 == 0) ? 12'hFFB : 12'hFFF;
         repeat (2) begin tick(); if (valid) bad++; end
      end
      check("bounce_quiet", bad, 0);
      press(12'hFFB, 4'd3, 1'b0, "bounce");

      // Backpressure: event frozen while ready is low and lines move.
      lines = 12'hFEF; ready = 1'b0;
      wait_valid(n);
      check("bp_latency", n, D + 3);
      check("bp_code", code, 4'd5);
      lines = 12'hEFF;
      bad = 0;
      repeat (20) begin tick(); if (!valid || code != 4'd5 || multi) bad++; end
      check("bp_hold", bad, 0);
      ready = 1'b1;
      tick();
      check("bp_accept", valid, 1'b0);
      bad = 0;
      repeat (10) begin tick(); if (valid) bad++; end
      check("bp_no_spurious", bad, 0);
      lines = 12'hFFF;
      repeat (10) tick();
      press(12'hEFF, 4'd9, 1'b0, "bp_repress");

      // Reset while an event is pending, line still held afterwards.
      lines = 12'hFFE; ready = 1'b0;
      wait_valid(n);
      check("rst_emit_latency", n, D + 3);
      rst = 1'b1;
      tick();
      check("rst_emit_clear", {code, valid, multi}, 6'd0);
      rst = 1'b0;
      wait_valid(n);
      check("rst_redetect_latency", n, D + 3);
      check("rst_redetect_code", code, 4'd1);
      ready = 1'b1;
      tick();
      lines = 12'hFFF;
      repeat (10) tick();

      // Random stimulus, checked cycle by cycle against the model.
      repeat (150) begin
         case ($urandom_range(0, 3))
            0: lines = 12'hFFF;
            1: begin one = 12'h001; lines = ~(one << $urandom_range(0, 11)); end
            2: lines = 12'($urandom);
            default: begin
               one = 12'h001;
               lines = ~((one << $urandom_range(0, 11)) | (one << $urandom_range(0, 11)));
            end
         endcase
         repeat ($urandom_range(1, 12)) begin
            ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      lines = 12'hFFF; ready = 1'b1;
      repeat (20) tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
